// File: rtl/frame_capture.sv
// frame_capture: counts FRAME_BITS from frame_sync, latches the shift-register word and offers it over valid/ready.
module frame_capture #(
  parameter int FRAME_BITS = 16,
  parameter int CNT_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        frame_sync,
  input  logic [15:0] bus_in,
  output logic [15:0] data_out,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        overrun,
  input  logic        clr_overrun,
  output logic        resync,
  output logic        busy,
  output logic [15:0] frame_count
);
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam logic [15:0] MASK = 16'((32'd1 << FRAME_BITS) - 32'd1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_BITS - 1);
  state_t state;
  logic [CNT_W-1:0] bit_cnt;
  logic done, ovr_set;
  always_comb begin
    done = (state == SHIFT) && (bit_cnt == LAST);
    ovr_set = done && data_valid && !data_ready;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      bit_cnt <= '0;
      data_out <= '0;
      data_valid <= 1'b0;
      overrun <= 1'b0;
      resync <= 1'b0;
      busy <= 1'b0;
      frame_count <= '0;
    end else begin
      resync <= 1'b0;
      overrun <= ovr_set | (overrun & ~clr_overrun);
      if (done) begin
        data_out <= bus_in & MASK;
        data_valid <= 1'b1;
        frame_count <= frame_count + 16'd1;
      end else if (data_valid && data_ready) data_valid <= 1'b0;
      if (state == IDLE) begin
        if (frame_sync && enable) begin
          state <= SHIFT;
          busy <= 1'b1;
          bit_cnt <= '0;
        end
      end else if (done) begin
        // a sync on the last bit chains straight into the next frame
        if (frame_sync && enable) bit_cnt <= '0;
        else begin
          state <= IDLE;
          busy <= 1'b0;
        end
      end else if (frame_sync) begin
        bit_cnt <= '0;
        resync <= 1'b1;
      end else bit_cnt <= bit_cnt + 1'b1;
    end
endmodule

// File: tb/tb_frame_capture.sv
// tb_frame_capture: directed vectors against frame_capture, with a behavioural shift register feeding bus_in.
module tb_frame_capture;
  logic clk = 1'b0;
  logic rst, enable, frame_sync, fs12, data_ready, clr_overrun, ser;
  logic [15:0] sr = '0;
  logic [15:0] data_out, frame_count, d12_out, d12_fc;
  logic data_valid, overrun, resync, busy, d12_valid, d12_ovr, d12_resync, d12_busy;
  logic [15:0] tx = '0;
  logic [15:0] nxt = '0;
  int tx_left = 0;
  int nb = 16;
  bit sel12 = 1'b0;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [15:0] word;
    logic [15:0] exp;
  } vec_t;
  vec_t v[4];

  always #5 clk = ~clk;
  always @(negedge clk) sr <= {sr[14:0], ser};

  frame_capture dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_sync(frame_sync), .bus_in(sr),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .overrun(overrun), .clr_overrun(clr_overrun), .resync(resync), .busy(busy),
    .frame_count(frame_count)
  );

  frame_capture #(.FRAME_BITS(12), .CNT_W(4)) dut12 (
    .clk(clk), .rst(rst), .enable(enable), .frame_sync(fs12), .bus_in(sr),
    .data_out(d12_out), .data_valid(d12_valid), .data_ready(1'b0),
    .overrun(d12_ovr), .clr_overrun(1'b0), .resync(d12_resync), .busy(d12_busy),
    .frame_count(d12_fc)
  );

  task automatic chk(input string n, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  // ser for this cycle is shifted at the coming falling edge; fs is sampled at the next rising edge
  task automatic tick(input bit fs);
    frame_sync = fs & ~sel12;
    fs12 = fs & sel12;
    if (tx_left > 0) begin
      ser = tx[15];
      tx = {tx[14:0], 1'b0};
      tx_left--;
    end else ser = 1'b0;
    if (fs) begin
      tx = nxt << (16 - nb);
      tx_left = nb;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    v[0] = '{16'h8001, 16'h8001};
    v[1] = '{16'h7FFE, 16'h7FFE};
    v[2] = '{16'h0000, 16'h0000};
    v[3] = '{16'hC0DE, 16'hC0DE};
    rst = 1'b1; enable = 1'b1; frame_sync = 1'b0; fs12 = 1'b0;
    data_ready = 1'b0; clr_overrun = 1'b0; ser = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", data_out, 16'h0);
    chk("rst_valid", {15'b0, data_valid}, 16'h0);
    chk("rst_ovr", {15'b0, overrun}, 16'h0);
    chk("rst_busy", {15'b0, busy}, 16'h0);
    chk("rst_fc", frame_count, 16'h0);
    chk("rst_resync", {15'b0, resync}, 16'h0);
    rst = 1'b0;
    tick(0);

    nxt = 16'hA5C3;
    tick(1);
    for (int i = 0; i < 16; i++) begin
      chk("single_busy", {15'b0, busy}, 16'h1);
      chk("single_novalid", {15'b0, data_valid}, 16'h0);
      tick(0);
    end
    chk("single_data", data_out, 16'hA5C3);
    chk("single_valid", {15'b0, data_valid}, 16'h1);
    chk("single_fc", frame_count, 16'd1);
    chk("single_busy_end", {15'b0, busy}, 16'h0);
    chk("single_ovr", {15'b0, overrun}, 16'h0);

    for (int i = 0; i < 5; i++) begin
      tick(0);
      chk("hold_valid", {15'b0, data_valid}, 16'h1);
      chk("hold_data", data_out, 16'hA5C3);
    end
    data_ready = 1'b1;
    tick(0);
    data_ready = 1'b0;
    chk("xfer_valid", {15'b0, data_valid}, 16'h0);

    data_ready = 1'b1;
    nxt = 16'h1234;
    tick(1);
    repeat (15) tick(0);
    nxt = 16'hFFFF;
    tick(1);
    chk("b2b_data1", data_out, 16'h1234);
    chk("b2b_valid1", {15'b0, data_valid}, 16'h1);
    chk("b2b_busy", {15'b0, busy}, 16'h1);
    for (int i = 0; i < 15; i++) begin
      tick(0);
      chk("b2b_busy2", {15'b0, busy}, 16'h1);
    end
    tick(0);
    chk("b2b_data2", data_out, 16'hFFFF);
    chk("b2b_valid2", {15'b0, data_valid}, 16'h1);
    chk("b2b_fc", frame_count, 16'd3);
    tick(0);
    data_ready = 1'b0;
    chk("b2b_drain", {15'b0, data_valid}, 16'h0);

    nxt = 16'h0001;
    tick(1);
    repeat (15) tick(0);
    nxt = 16'h0002;
    tick(1);
    chk("ovr_first", {15'b0, overrun}, 16'h0);
    repeat (15) tick(0);
    tick(0);
    chk("ovr_data", data_out, 16'h0002);
    chk("ovr_set", {15'b0, overrun}, 16'h1);
    chk("ovr_fc", frame_count, 16'd5);
    nxt = 16'h0003;
    tick(1);
    repeat (15) tick(0);
    clr_overrun = 1'b1;
    tick(0);
    clr_overrun = 1'b0;
    chk("ovr_setwins", {15'b0, overrun}, 16'h1);
    chk("ovr_data3", data_out, 16'h0003);
    tick(0);
    chk("ovr_sticky", {15'b0, overrun}, 16'h1);
    clr_overrun = 1'b1;
    tick(0);
    clr_overrun = 1'b0;
    chk("ovr_clear", {15'b0, overrun}, 16'h0);
    data_ready = 1'b1;
    tick(0);
    data_ready = 1'b0;

    nxt = 16'h1111;
    tick(1);
    repeat (6) tick(0);
    chk("rs_idle", {15'b0, resync}, 16'h0);
    nxt = 16'h5A5A;
    tick(1);
    chk("rs_pulse", {15'b0, resync}, 16'h1);
    tick(0);
    chk("rs_one", {15'b0, resync}, 16'h0);
    repeat (8) tick(0);
    chk("rs_noout", {15'b0, data_valid}, 16'h0);
    chk("rs_fc_hold", frame_count, 16'd6);
    repeat (6) tick(0);
    chk("rs_early", {15'b0, data_valid}, 16'h0);
    tick(0);
    chk("rs_data", data_out, 16'h5A5A);
    chk("rs_valid", {15'b0, data_valid}, 16'h1);
    chk("rs_fc", frame_count, 16'd7);
    data_ready = 1'b1;
    tick(0);
    data_ready = 1'b0;

    for (int i = 0; i < 4; i++) begin
      nxt = v[i].word;
      tick(1);
      repeat (16) tick(0);
      chk("vec_data", data_out, v[i].exp);
      chk("vec_fc", frame_count, 16'(8 + i));
      data_ready = 1'b1;
      tick(0);
      data_ready = 1'b0;
      chk("vec_drain", {15'b0, data_valid}, 16'h0);
    end

    enable = 1'b0;
    tick(1);
    chk("en_ignore", {15'b0, busy}, 16'h0);
    enable = 1'b1;
    nxt = 16'h00FF;
    tick(1);
    enable = 1'b0;
    repeat (16) tick(0);
    enable = 1'b1;
    chk("en_midframe", data_out, 16'h00FF);

    sel12 = 1'b1;
    nb = 12;
    nxt = 16'h0ABC;
    tick(1);
    repeat (11) tick(0);
    chk("p12_early", {15'b0, d12_valid}, 16'h0);
    tick(0);
    chk("p12_data", d12_out, 16'h0ABC);
    chk("p12_valid", {15'b0, d12_valid}, 16'h1);
    sel12 = 1'b0;
    nb = 16;

    nxt = 16'hFFFF;
    tick(1);
    repeat (8) tick(0);
    rst = 1'b1;
    #1;
    chk("arst_data", data_out, 16'h0);
    chk("arst_valid", {15'b0, data_valid}, 16'h0);
    chk("arst_busy", {15'b0, busy}, 16'h0);
    chk("arst_fc", frame_count, 16'h0);
    chk("arst_ovr", {15'b0, overrun}, 16'h0);
    tick(0);
    rst = 1'b0;
    repeat (12) tick(0);
    chk("arst_noframe", {15'b0, data_valid}, 16'h0);
    chk("arst_fc2", frame_count, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
